// File: rtl/ucore_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ucore_pkg
// Brief    : Shared defaults, count-width helper and status bit indices.
// Revision : 1.0
// ============================================================================
package ucore_pkg;

  localparam int UCORE_WIDTH_DEF = 32;
  localparam int UCORE_DEPTH_DEF = 4;

  // Error flag positions, shared with any packed status port
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UNF_BIT = 1;
  localparam int ERR_W       = 2;

  // Occupancy needs one bit more than a pointer to represent "full"
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucore_port_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : ucore_port_fifo_if
// Brief    : Producer stream, core port and status bundle of the port FIFO.
// Revision : 1.0
// ============================================================================
interface ucore_port_fifo_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 3
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             port_valid;
  logic [WIDTH-1:0] port_data;
  logic             pop_req;
  logic [CW-1:0]    count;
  logic             err_ovf;
  logic             err_unf;
  logic             err_clr;

  modport slave (
    input  s_valid, s_data, pop_req, err_clr,
    output s_ready, port_valid, port_data, count, err_ovf, err_unf
  );

  modport master (
    output s_valid, s_data, pop_req, err_clr,
    input  s_ready, port_valid, port_data, count, err_ovf, err_unf
  );
endinterface
`default_nettype wire

// File: rtl/ucore_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : ucore_fifo_mem
// Brief    : DEPTH x WIDTH register array, one write port, async read port.
// Revision : 1.0
// ============================================================================
module ucore_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Cleared on reset so the head word is never X while empty
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/ucore_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ucore_port_fifo
// Brief    : First-word-fall-through input buffer feeding a ucore FSM port.
// Revision : 1.0
// ============================================================================
module ucore_port_fifo
  import ucore_pkg::*;
#(
  parameter int WIDTH = UCORE_WIDTH_DEF,
  parameter int DEPTH = UCORE_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               aresetn,
  ucore_port_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_MAX = {CW{1'b1}};

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [CW-1:0]    stall_q,  stall_d;
  logic             s_ready_q, s_ready_d;
  logic [ERR_W-1:0] err_q,    err_d;

  logic             w_push;
  logic             w_pop;
  logic             w_stall;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [WIDTH-1:0] w_head;

  always_comb begin
    w_push    = bus.s_valid && s_ready_q;
    w_pop     = bus.pop_req && (count_q != '0);
    w_stall   = bus.s_valid && !s_ready_q;
    w_unf_set = bus.pop_req && (count_q == '0);

    wr_ptr_d  = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(w_push) - CW'(w_pop);
    s_ready_d = (count_d < FULL_CNT);

    // Saturating run length of blocked push attempts
    if (!w_stall) begin
      stall_d = '0;
    end else if (stall_q == STALL_MAX) begin
      stall_d = stall_q;
    end else begin
      stall_d = stall_q + CW'(1);
    end
    w_ovf_set = (stall_d > FULL_CNT);

    // A set condition wins over a same-cycle clear
    err_d              = err_q;
    err_d[ERR_OVF_BIT] = w_ovf_set | (err_q[ERR_OVF_BIT] & ~bus.err_clr);
    err_d[ERR_UNF_BIT] = w_unf_set | (err_q[ERR_UNF_BIT] & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      stall_q   <= '0;
      s_ready_q <= 1'b0;
      err_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      stall_q   <= stall_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
    end
  end

  ucore_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .aresetn (aresetn),
    .we_i    (w_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.s_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_head)
  );

  assign bus.s_ready    = s_ready_q;
  assign bus.port_valid = (count_q != '0);
  assign bus.port_data  = w_head;
  assign bus.count      = count_q;
  assign bus.err_ovf    = err_q[ERR_OVF_BIT];
  assign bus.err_unf    = err_q[ERR_UNF_BIT];

endmodule
`default_nettype wire

// File: doc/ucore_port_fifo.md
Name: ucore_port_fifo

Overview:
- Input-side buffer that sits directly upstream of a generated ucore_* FSM core.
- Accepts a valid/ready stream from the surrounding system and presents the head word as a level-held input port with a valid flag.
- The core consumes entries by driving a pop output port, which connects to pop_req here.
- Decouples producer bursts from the core's multi-cycle program blocks. Reports occupancy and sticky error flags that the core can read as further input ports.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 4, number of entries; power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived, localparam)

Ports:
clk  input  1  global clock
aresetn  input  1  active-low asynchronous reset
s_valid  input  1  upstream word valid
s_ready  output  1  buffer can accept a word this cycle
s_data  input  WIDTH  upstream word
port_valid  output  1  head word valid (buffer non-empty); drives core input port
port_data  output  WIDTH  head word; drives core input port
pop_req  input  1  driven by a registered core output port; high = consume head this cycle
count  output  AW+1  current occupancy, 0..DEPTH
err_ovf  output  1  sticky: push attempted (s_valid) while s_ready low for more than 2^AW consecutive cycles
err_unf  output  1  sticky: pop_req high while empty
err_clr  input  1  synchronous clear of both sticky flags

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (aresetn). All state registers reset asynchronously on the falling edge of aresetn and are released on the next clk edge.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0.
  - s_ready=0 (registered); it rises to 1 on the first clk edge after aresetn is released.
  - port_valid=0, err_ovf=0, err_unf=0.
  - port_data is don't-care but must not be X in simulation: storage resets to 0.
- Push: s_valid && s_ready at a clk edge writes s_data at wr_ptr, then wr_ptr++ (modulo DEPTH).
- Pop: pop_req && port_valid at a clk edge advances rd_ptr++ (modulo DEPTH).
- pop_req is a level. Every cycle it is high with data present pops one entry. The core must drop it after one cycle to pop once.
- First-word-fall-through: a word pushed at edge N appears on port_data/port_valid after edge N (zero extra latency). port_data = mem[rd_ptr], read combinationally from registers.
- count_next = count + push - pop, where push and pop are the qualified events above.
- count == DEPTH only when full. Pointer wrap is handled by the modulo arithmetic; count distinguishes full from empty.
- port_valid = (count != 0), combinational from the registered count.
- s_ready is registered: s_ready <= (count_next < DEPTH). It is never high while full, so a push never overwrites.
- Simultaneous push and pop:
  - Non-empty, not full: both occur; count unchanged.
  - Full: s_ready is 0, so only the pop happens. s_ready rises the following cycle.
  - Empty: the push happens and the pop is ignored (port_valid=0); err_unf sets.
- err_unf sets on any cycle with pop_req && !port_valid.
- err_ovf:
  - A saturating stall counter of AW+1 bits counts consecutive cycles with s_valid && !s_ready.
  - err_ovf sets when the counter exceeds 2^AW.
  - The counter clears on any cycle without that condition.
- err_clr clears both flags. If a set condition and err_clr occur in the same cycle, set wins.
- Reset mid-operation: all contents are discarded immediately; port_valid drops asynchronously with count.
- Producer protocol: the producer must hold s_data stable while s_valid is high and s_ready is low. This is not checked.

Decomposition:
- Shared package ucore_pkg: DEPTH/WIDTH defaults, the count width function, and the err flag bit indices. These are reused when err_* is packed into a status port.
- One natural sub-module: ucore_fifo_mem, a DEPTH x WIDTH register array with a write port and an asynchronous read port, reset to 0.
- Pointer, count, ready and flag logic stay in ucore_port_fifo.

Test Plan:
1. Reset then idle: hold aresetn=0 for 3 cycles, release. Expect s_ready 0 during reset, 1 one edge after release; port_valid=0; count=0.
2. Fill to full: push 0xA0..0xA3 on consecutive cycles with pop_req=0. Expect count 1,2,3,4; s_ready=0 after the 4th push; port_data=0xA0 throughout.
3. Drain with wrap: from full, pop 2, push 0xB0,0xB1, pop 4. Expect pop order 0xA2,0xA3,0xB0,0xB1; count reaches 0; port_valid=0.
4. Simultaneous push and pop at count=2: one cycle with both events. Expect count stays 2 and the head advances.
5. Simultaneous push and pop at count=4: only the pop occurs (count=3), s_ready=1 next cycle, and the held s_data is accepted on the following edge.
6. Errors:
   - pop_req=1 while empty: err_unf=1.
   - s_valid held while full for 5 cycles with DEPTH=4: err_ovf=1.
   - err_clr pulsed: both flags 0.
   - err_clr together with a concurrent pop on empty: err_unf stays 1.
